user_uart_tx: RTL and testbench

Byte-wide UART transmitter (8N1) for the user project area. It drives a serial line on an `mprj_io` pad, in the same direction and format that the testbench UART monitor receives. Bytes enter through a valid/ready handshake into a small FIFO; these come from logic-analyzer-driven or internal user logic. A bit-timing state machine serialises them LSB-first at a runtime-programmable bit period.

---
 rtl/user_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_user_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/user_uart_tx.sv
// Byte-wide 8N1 UART transmitter with a small input FIFO and a runtime bit period.
// Bytes are sent LSB-first; the idle line level is high.
module user_uart_tx #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_i,
  input  logic                            enable_i,
  input  logic [DIV_W-1:0]                div_i,
  input  logic [7:0]                      tx_data_i,
  input  logic                            tx_valid_i,
  output logic                            tx_ready_o,
  output logic                            tx_o,
  output logic                            busy_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // FIFO storage and bookkeeping
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0] level_q, level_d;
  logic            push, pop;
  logic            fifo_empty;
  logic [7:0]      head;

  // Serialiser state
  state_e          state_q, state_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_q, bit_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] tmr_q, tmr_d;
  logic            tx_q, tx_d;
  logic [DIV_W-1:0] period_eff;
  logic            can_start;

  assign tx_ready_o   = (level_q != LvlW'(FIFO_DEPTH));
  assign fifo_empty   = (level_q == '0);
  assign fifo_level_o = level_q;
  assign head         = mem_q[rd_ptr_q];
  assign push         = tx_valid_i && tx_ready_o;

  assign period_eff = (div_i == '0) ? DIV_W'(1) : div_i;
  assign can_start  = enable_i && !fifo_empty;

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LvlW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LvlW'(1);
    end
  end

  // Data storage needs no reset; validity is tracked by the level counter.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= tx_data_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    period_d = period_q;
    tmr_d    = tmr_q;
    tx_d     = tx_q;
    pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (can_start) begin
          pop      = 1'b1;
          shift_d  = head;
          period_d = period_eff;
          tmr_d    = period_eff - DIV_W'(1);
          bit_d    = '0;
          state_d  = StStart;
          tx_d     = 1'b0;
        end
      end

      StStart: begin
        if (tmr_q == '0) begin
          state_d = StData;
          tmr_d   = period_q - DIV_W'(1);
          tx_d    = shift_q[0];
        end else begin
          tmr_d = tmr_q - DIV_W'(1);
        end
      end

      StData: begin
        if (tmr_q == '0) begin
          tmr_d   = period_q - DIV_W'(1);
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = shift_q[1];
          end
        end else begin
          tmr_d = tmr_q - DIV_W'(1);
        end
      end

      StStop: begin
        if (tmr_q == '0) begin
          // Chain straight into the next start bit so queued bytes leave no gap.
          if (can_start) begin
            pop      = 1'b1;
            shift_d  = head;
            period_d = period_eff;
            tmr_d    = period_eff - DIV_W'(1);
            bit_d    = '0;
            state_d  = StStart;
            tx_d     = 1'b0;
          end else begin
            state_d = StIdle;
            tx_d    = 1'b1;
          end
        end else begin
          tmr_d = tmr_q - DIV_W'(1);
        end
      end

      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      bit_q    <= '0;
      period_q <= '0;
      tmr_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      period_q <= period_d;
      tmr_q    <= tmr_d;
      tx_q     <= tx_d;
    end
  end

  assign tx_o   = tx_q;
  assign busy_o = (state_q != StIdle);

endmodule

// File: tb/tb_user_uart_tx.sv
// Directed-plus-random bench for user_uart_tx; expected line levels come from the 8N1 frame
// rule (bit index = cycle / P) rather than from any model of the serialiser's internals.
module tb_user_uart_tx;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned DIV_W      = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             enable;
  logic [DIV_W-1:0] div;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx;
  logic             busy;
  logic [2:0]       fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  user_uart_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .DIV_W     (DIV_W)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .enable_i    (enable),
    .div_i       (div),
    .tx_data_i   (tx_data),
    .tx_valid_i  (tx_valid),
    .tx_ready_o  (tx_ready),
    .tx_o        (tx),
    .busy_o      (busy),
    .fifo_level_o(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Line level at cycle c of a frame carrying byte b with bit period p.
  function automatic logic exp_tx(input logic [7:0] b, input int p, input int c);
    int k;
    k = c / p;
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Checks frame cycles [from, to); entered at cycle 'from', leaves at cycle 'to'.
  task automatic run_frame(input logic [7:0] b, input int p, input int from, input int to);
    for (int c = from; c < to; c++) begin
      chk($sformatf("tx b=%02h p=%0d c=%0d", b, p, c), tx, exp_tx(b, p, c));
      chk($sformatf("busy b=%02h c=%0d", b, c), busy, 1'b1);
      step();
    end
  endtask

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  // Idle, enabled, empty FIFO: accept one byte and check the whole frame.
  task automatic single(input logic [7:0] b, input int d);
    int p;
    p   = (d == 0) ? 1 : d;
    div = DIV_W'(d);
    push(b);
    chk("accept level", fifo_level, 1);
    chk("accept tx idle", tx, 1'b1);
    chk("accept busy", busy, 1'b0);
    step();
    chk("pop level", fifo_level, 0);
    run_frame(b, p, 0, 10 * p);
    chk("end busy", busy, 1'b0);
    chk("end tx", tx, 1'b1);
  endtask

  initial begin
    logic [7:0] q [$];
    logic [7:0] b;
    int p;

    rst      = 1'b1;
    enable   = 1'b0;
    div      = DIV_W'(4);
    tx_data  = 8'h5A;
    tx_valid = 1'b1;

    // Reset holds off all pushes.
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rst tx", tx, 1'b1);
      chk("rst busy", busy, 1'b0);
      chk("rst ready", tx_ready, 1'b1);
      chk("rst level", fifo_level, 0);
    end
    tx_valid = 1'b0;
    rst      = 1'b0;
    step();
    chk("post rst level", fifo_level, 0);
    enable = 1'b1;

    // Single byte at P=4, then random bytes and divisors.
    single(8'hA5, 4);
    for (int i = 0; i < 4; i++) begin
      single(8'($urandom), int'($urandom_range(0, 5)));
    end

    // Backpressure: fill the FIFO while disabled, hold a fifth byte.
    p       = int'($urandom_range(1, 3));
    div     = DIV_W'(p);
    enable  = 1'b0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    chk("full level", fifo_level, 4);
    chk("full ready", tx_ready, 1'b0);
    tx_data  = 8'h05;
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full hold level", fifo_level, 4);
      chk("full hold tx", tx, 1'b1);
    end
    enable = 1'b1;
    step();
    chk("first pop level", fifo_level, 3);
    chk("first pop ready", tx_ready, 1'b1);
    chk("bp tx c0", tx, 1'b0);
    step();
    tx_valid = 1'b0;
    chk("late push level", fifo_level, 4);
    run_frame(8'h01, p, 1, 10 * p);
    for (int i = 2; i <= 5; i++) run_frame(8'(i), p, 0, 10 * p);
    chk("bp end busy", busy, 1'b0);
    chk("bp end level", fifo_level, 0);

    // Enable dropped mid-frame finishes the frame and holds the queue.
    div    = DIV_W'(4);
    enable = 1'b0;
    push(8'h3C);
    push(8'h7E);
    chk("en queued", fifo_level, 2);
    enable = 1'b1;
    step();
    run_frame(8'h3C, 4, 0, 20);
    enable = 1'b0;
    run_frame(8'h3C, 4, 20, 40);
    for (int i = 0; i < 10; i++) begin
      chk("en off tx", tx, 1'b1);
      chk("en off busy", busy, 1'b0);
      chk("en off level", fifo_level, 1);
      step();
    end
    enable = 1'b1;
    step();
    run_frame(8'h7E, 4, 0, 40);
    chk("en end busy", busy, 1'b0);

    // div 0 behaves as 1.
    single(8'hFF, 0);

    // Divisor change mid-frame only affects the next frame.
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      push(b);
    end
    div    = DIV_W'(4);
    enable = 1'b1;
    step();
    b = q.pop_front();
    run_frame(b, 4, 0, 15);
    div = DIV_W'(8);
    run_frame(b, 4, 15, 40);
    b = q.pop_front();
    run_frame(b, 8, 0, 80);
    chk("div end busy", busy, 1'b0);

    // Reset in data bit 3 abandons the frame and empties the FIFO.
    div    = DIV_W'(4);
    enable = 1'b0;
    push(8'h55);
    push(8'($urandom));
    push(8'($urandom));
    enable = 1'b1;
    step();
    run_frame(8'h55, 4, 0, 17);
    rst = 1'b1;
    #1;
    chk("mid rst tx", tx, 1'b1);
    chk("mid rst level", fifo_level, 0);
    chk("mid rst busy", busy, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    single(8'h81, 4);
    for (int i = 0; i < 20; i++) begin
      chk("after rst tx", tx, 1'b1);
      chk("after rst level", fifo_level, 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
